line_rasterizer: RTL and testbench

LINE_RASTERIZER -- requirements
Module: line_rasterizer

---
 rtl/line_rasterizer.sv | 145 ++++++++++++++
 tb/tb_line_rasterizer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: takes one line request and streams its pixels,
// one per cycle, under a valid/ready handshake to a pixel sink.
module line_rasterizer #(
  parameter int XW = 9,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  input  logic [XW-1:0] i_x1,
  input  logic [YW-1:0] i_y1,
  input  logic [2:0]    i_color,
  input  logic          i_pix_ready,
  output logic          o_plot,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [2:0]    o_color,
  output logic          o_busy,
  output logic          o_done
);

  // Error term is wide enough for either axis span plus sign and one guard bit.
  localparam int EW = ((XW > YW) ? XW : YW) + 2;
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

  state_t state_reg, state_next;

  logic [XW-1:0]        x0_reg, x1_reg, cur_x_reg;
  logic [YW-1:0]        y0_reg, y1_reg, cur_y_reg;
  logic [2:0]           color_reg;
  logic signed [EW-1:0] dx_reg, dy_reg, err_reg;
  logic                 sx_neg_reg, sy_neg_reg;

  logic [XW-1:0]        abs_dx;
  logic [YW-1:0]        abs_dy;
  logic signed [EW-1:0] dx_init, dy_init;
  logic signed [EW:0]   e2;
  logic                 step_x, step_y, at_end;
  logic signed [EW-1:0] err_next;
  logic [XW-1:0]        cur_x_next;
  logic [YW-1:0]        cur_y_next;

  assign abs_dx  = (x1_reg >= x0_reg) ? (x1_reg - x0_reg) : (x0_reg - x1_reg);
  assign abs_dy  = (y1_reg >= y0_reg) ? (y1_reg - y0_reg) : (y0_reg - y1_reg);
  assign dx_init = signed'({{(EW-XW){1'b0}}, abs_dx});
  assign dy_init = -signed'({{(EW-YW){1'b0}}, abs_dy});

  assign e2     = {err_reg, 1'b0};
  assign step_x = (e2 >= dy_reg);
  assign step_y = (e2 <= dx_reg);
  assign at_end = (cur_x_reg == x1_reg) && (cur_y_reg == y1_reg);

  // Both axis decisions use the pre-update error, so they are evaluated together.
  always_comb begin
    err_next   = err_reg;
    cur_x_next = cur_x_reg;
    cur_y_next = cur_y_reg;
    if (step_x) begin
      err_next   = err_next + dy_reg;
      cur_x_next = sx_neg_reg ? (cur_x_reg - X_ONE) : (cur_x_reg + X_ONE);
    end
    if (step_y) begin
      err_next   = err_next + dx_reg;
      cur_y_next = sy_neg_reg ? (cur_y_reg - Y_ONE) : (cur_y_reg + Y_ONE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = INIT;
      INIT:    state_next = DRAW;
      DRAW:    if (i_pix_ready && at_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_reg     <= '0;
      y0_reg     <= '0;
      x1_reg     <= '0;
      y1_reg     <= '0;
      color_reg  <= '0;
      cur_x_reg  <= '0;
      cur_y_reg  <= '0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      err_reg    <= '0;
      sx_neg_reg <= 1'b0;
      sy_neg_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            x0_reg    <= i_x0;
            y0_reg    <= i_y0;
            x1_reg    <= i_x1;
            y1_reg    <= i_y1;
            color_reg <= i_color;
          end
        end
        INIT: begin
          cur_x_reg  <= x0_reg;
          cur_y_reg  <= y0_reg;
          dx_reg     <= dx_init;
          dy_reg     <= dy_init;
          err_reg    <= dx_init + dy_init;
          sx_neg_reg <= !(x0_reg < x1_reg);
          sy_neg_reg <= !(y0_reg < y1_reg);
        end
        DRAW: begin
          if (i_pix_ready && !at_end) begin
            cur_x_reg <= cur_x_next;
            cur_y_reg <= cur_y_next;
            err_reg   <= err_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_plot  = (state_reg == DRAW);
  assign o_busy  = (state_reg != IDLE);
  assign o_done  = (state_reg == DONE);
  assign o_x     = cur_x_reg;
  assign o_y     = cur_y_reg;
  assign o_color = color_reg;

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer: directed lines push expected pixels,
// a negedge monitor pops and compares every accepted pixel and done pulse.
module tb_line_rasterizer;
  localparam int XW = 9;
  localparam int YW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [XW-1:0] i_x0, i_x1;
  logic [YW-1:0] i_y0, i_y1;
  logic [2:0]    i_color;
  logic          i_pix_ready;
  logic          o_plot, o_busy, o_done;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic [2:0]    o_color;

  line_rasterizer #(.XW(XW), .YW(YW)) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1), .i_color(i_color),
    .i_pix_ready(i_pix_ready),
    .o_plot(o_plot), .o_x(o_x), .o_y(o_y), .o_color(o_color),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int x;
    int y_lo;
    int y_hi;
    int color;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   acc_count = 0;
  bit   ready_toggle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    i_pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_pix_ready = ready_toggle ? !i_pix_ready : 1'b1;
    end
  end

  // Monitor: every accepted pixel and every done pulse must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      if (o_plot && i_pix_ready) begin
        checks++;
        if (sb.size() == 0 || sb[0].is_done) begin
          $display("FAIL unexpected_pixel: got (%0d,%0d) but no pixel expected", o_x, o_y);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (int'(o_x) == e.x && int'(o_y) >= e.y_lo && int'(o_y) <= e.y_hi
              && int'(o_color) == e.color) begin
            passes++;
            $display("pix (%0d,%0d) c%0d ok", o_x, o_y, o_color);
          end else begin
            $display("FAIL pixel: got (%0d,%0d) c%0d, need (%0d,%0d..%0d) c%0d",
                     o_x, o_y, o_color, e.x, e.y_lo, e.y_hi, e.color);
          end
        end
        last_acc = cyc;
        acc_count++;
      end
      if (o_done) begin
        checks++;
        if (sb.size() == 0 || !sb[0].is_done) begin
          $display("FAIL unexpected_done: done pulse with %0d entries pending", sb.size());
        end else begin
          void'(sb.pop_front());
          if (cyc == last_acc + 1) begin
            passes++;
            $display("done ok");
          end else begin
            $display("FAIL done_timing: done at cycle %0d, need %0d", cyc, last_acc + 1);
          end
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, need %0d", name, act, exp);
  endtask

  task automatic push_pix(int x, int y, int c);
    sb.push_back('{1'b0, x, y, y, c});
  endtask

  task automatic push_done();
    sb.push_back('{1'b1, 0, 0, 0, 0});
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, "_plot"},  int'(o_plot), 0);
    chk({tag, "_busy"},  int'(o_busy), 0);
    chk({tag, "_done"},  int'(o_done), 0);
    chk({tag, "_x"},     int'(o_x), 0);
    chk({tag, "_y"},     int'(o_y), 0);
    chk({tag, "_color"}, int'(o_color), 0);
  endtask

  // Issues a start, then scrambles inputs and checks INIT and first-plot timing.
  task automatic start_line(int x0, int y0, int x1, int y1, int c);
    @(posedge clk);
    #1;
    i_x0 = XW'(x0); i_y0 = YW'(y0); i_x1 = XW'(x1); i_y1 = YW'(y1);
    i_color = 3'(c);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_x0 = XW'(x0 + 37); i_y0 = YW'(y0 + 11); i_x1 = XW'(x1 + 5);
    i_y1 = YW'(y1 + 3);  i_color = 3'(c + 1);
    chk("init_busy", int'(o_busy), 1);
    chk("init_plot", int'(o_plot), 0);
    @(posedge clk);
    #1;
    chk("first_plot", int'(o_plot), 1);
    chk("first_x", int'(o_x), x0);
    chk("first_y", int'(o_y), y0);
  endtask

  task automatic wait_idle(int maxc);
    int n = 0;
    while ((sb.size() != 0 || o_busy) && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("line_complete", int'(n < maxc), 1);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b0;
    i_start = 1'b0;
    i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0; i_color = '0;
    #3;
    check_zero_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Horizontal line
    for (int i = 0; i <= 4; i++) push_pix(i, 0, 5);
    push_done();
    start_line(0, 0, 4, 0, 5);
    wait_idle(50);

    // Degenerate single-pixel line
    push_pix(7, 3, 2);
    push_done();
    start_line(7, 3, 7, 3, 2);
    wait_idle(50);

    // Steep line with both directions negative
    push_pix(10, 20, 3); push_pix(10, 19, 3); push_pix(9, 18, 3); push_pix(9, 17, 3);
    push_pix(9, 16, 3);  push_pix(8, 15, 3);  push_pix(8, 14, 3);
    push_done();
    start_line(10, 20, 8, 14, 3);
    wait_idle(50);

    // Diagonal with sink stalling every other cycle
    ready_toggle = 1;
    for (int i = 0; i <= 3; i++) push_pix(i, i, 1);
    push_done();
    start_line(0, 0, 3, 3, 1);
    wait_idle(50);
    ready_toggle = 0;

    // Start pulses during an active line must be ignored
    push_pix(2, 5, 6); push_pix(3, 6, 6); push_pix(4, 6, 6); push_pix(5, 7, 6);
    push_pix(6, 7, 6);
    push_done();
    start_line(2, 5, 6, 7, 6);
    i_x0 = 9'd100; i_y0 = 8'd100; i_x1 = 9'd0; i_y1 = 8'd0; i_color = 3'd0;
    i_start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_idle(50);
    repeat (3) @(posedge clk);
    #1;
    chk("no_queued_start", int'(o_busy), 0);

    // Long line abandoned by reset after 100 accepted pixels
    for (int i = 0; i < 100; i++) begin
      int ylo;
      ylo = (i * 239) / 319;
      sb.push_back('{1'b0, i, ylo, ylo + 1, 7});
    end
    base = acc_count;
    start_line(0, 0, 319, 239, 7);
    n = 0;
    while (acc_count - base < 100 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hundred_pixels", acc_count - base, 100);
    reset = 1'b0;
    #1;
    check_zero_outputs("abort");
    chk("abort_queue_empty", sb.size(), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fresh line after the abort
    push_pix(1, 1, 4); push_pix(2, 1, 4);
    push_done();
    start_line(1, 1, 2, 1, 4);
    wait_idle(50);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
